// File: rtl/c3po_pkg.sv
// Shared types for the C-3PO egress merge: the buffered word format and arbiter states.
package c3po_pkg;

  localparam int C3PO_WORD_BYTES = 32;
  localparam int C3PO_DATA_W     = C3PO_WORD_BYTES * 8;

  typedef struct packed {
    logic                   sop;
    logic                   eop;
    logic [7:0]             vbc;
    logic [C3PO_DATA_W-1:0] data;
  } c3po_word_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } c3po_arb_state_t;

  // Port index increment that wraps at ports-1 back to zero.
  function automatic logic [3:0] port_inc(input logic [3:0] p, input int ports);
    return (int'(p) == ports - 1) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/c3po_sync_fifo.sv
// Single-clock FIFO with extended pointers; the pointer MSB separates full from empty.
module c3po_sync_fifo #(
  parameter int WIDTH = 266,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/c3po_egress_merge.sv
// Merges per-port unpacker word streams onto one egress bus with packet-atomic round-robin.
// Egress handshake: a word transfers on a rising edge where out_val & out_ready; while
// out_val & !out_ready every out_* field holds, and all fields read zero when out_val=0.
module c3po_egress_merge
  import c3po_pkg::*;
#(
  parameter int PORTS_P      = 4,
  parameter int FIFO_DEPTH_P = 4
) (
  input  logic                             clk,
  input  logic                             reset_L,
  input  logic [PORTS_P-1:0]               in_val,
  input  logic [PORTS_P-1:0]               in_sop,
  input  logic [PORTS_P-1:0]               in_eop,
  input  logic [PORTS_P*8-1:0]             in_vbc,
  input  logic [PORTS_P*C3PO_DATA_W-1:0]   in_data,
  input  logic                             out_ready,
  output logic                             out_val,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [7:0]                       out_vbc,
  output logic [C3PO_DATA_W-1:0]           out_data,
  output logic [3:0]                       out_port,
  output logic [PORTS_P-1:0]               ovf,
  output logic [PORTS_P-1:0]               nosop_err,
  output logic                             idle,
  output c3po_arb_state_t                  arb_state,
  output logic [3:0]                       arb_rr
);

  c3po_arb_state_t state, state_nx;
  logic [3:0]      gnt, gnt_nx;
  logic [3:0]      rr_ptr, rr_nx;

  logic [PORTS_P-1:0] empty;
  logic [PORTS_P-1:0] full;
  logic [PORTS_P-1:0] push;
  logic [PORTS_P-1:0] pop;
  logic [PORTS_P-1:0] discard;
  c3po_word_t         wr_word [PORTS_P];
  c3po_word_t         head    [PORTS_P];

  c3po_word_t sel;
  logic       sel_empty;
  logic       found;
  logic [4:0] idx;

  for (genvar g = 0; g < PORTS_P; g++) begin : g_port
    assign wr_word[g] = '{sop:  in_sop[g],
                          eop:  in_eop[g],
                          vbc:  in_vbc[g*8 +: 8],
                          data: in_data[g*C3PO_DATA_W +: C3PO_DATA_W]};
    assign push[g] = in_val[g] & (~full[g] | pop[g]);

    c3po_sync_fifo #(
      .WIDTH($bits(c3po_word_t)),
      .DEPTH(FIFO_DEPTH_P)
    ) u_fifo (
      .clk    (clk),
      .reset_L(reset_L),
      .push   (push[g]),
      .pop    (pop[g]),
      .wdata  (wr_word[g]),
      .head   (head[g]),
      .empty  (empty[g]),
      .full   (full[g])
    );
  end

  always_comb begin
    sel       = '0;
    sel_empty = 1'b1;
    for (int i = 0; i < PORTS_P; i++) begin
      if (gnt == 4'(i)) begin
        sel       = head[i];
        sel_empty = empty[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state  <= ARB_IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      gnt    <= gnt_nx;
      rr_ptr <= rr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    rr_nx    = rr_ptr;
    pop      = '0;
    discard  = '0;
    found    = 1'b0;
    idx      = '0;
    out_val  = 1'b0;
    out_sop  = 1'b0;
    out_eop  = 1'b0;
    out_vbc  = '0;
    out_data = '0;
    out_port = '0;
    case (state)
      ARB_IDLE: begin
        // Outside a packet every head should be a packet start; anything else is junk.
        for (int i = 0; i < PORTS_P; i++) begin
          discard[i] = ~empty[i] & ~head[i].sop;
        end
        pop = discard;
        for (int k = 0; k < PORTS_P; k++) begin
          idx = {1'b0, rr_ptr} + 5'(k);
          if (idx >= 5'(PORTS_P)) idx = idx - 5'(PORTS_P);
          for (int i = 0; i < PORTS_P; i++) begin
            if (!found && idx == 5'(i) && !empty[i] && head[i].sop) begin
              found  = 1'b1;
              gnt_nx = 4'(i);
            end
          end
        end
        if (found) state_nx = ARB_XFER;
      end
      ARB_XFER: begin
        out_val = ~sel_empty;
        if (out_val) begin
          out_sop  = sel.sop;
          out_eop  = sel.eop;
          out_vbc  = sel.vbc;
          out_data = sel.data;
          out_port = gnt;
        end
        // Only eop closes the packet; a stray mid-packet sop is forwarded as-is.
        for (int i = 0; i < PORTS_P; i++) begin
          pop[i] = (gnt == 4'(i)) & out_val & out_ready;
        end
        if (out_val && out_ready && sel.eop) begin
          state_nx = ARB_IDLE;
          rr_nx    = port_inc(gnt, PORTS_P);
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ovf       <= '0;
      nosop_err <= '0;
    end else begin
      ovf       <= ovf | (in_val & full & ~pop);
      nosop_err <= nosop_err | discard;
    end
  end

  assign idle      = (state == ARB_IDLE) & (&empty);
  assign arb_state = state;
  assign arb_rr    = rr_ptr;

endmodule
